disable_sequencer: RTL

- Parametrised successor to the drivetrain sensor-disable handler: N masked sensor channels, configurable hold and pause durations, and optional retrigger.
- Adds a strike counter with latched lockout, plus cause capture for debug.
- Sits between the sensor front-ends and the drivetrain PWM/motor enable logic.
- Drives `enable` (motor gate) and `pause` (navigation-suspend flag).

---
 rtl/disable_pkg.sv | 44 ++++
 rtl/sns_trig_detect.sv | 37 +++
 rtl/disable_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/disable_pkg.sv
// Shared types and constants for the sensor-disable sequencer.
// Holds the FSM state encoding, the 100 MHz default timings and a helper
// that sizes the strike counter from the configured strike limit.
package disable_pkg;

  // FSM state encoding; also exported on the debug 'state' port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RESUME  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Default timings for a 100 MHz system clock.
  localparam int DEF_CLK_HZ    = 100_000_000;
  localparam int DEF_HOLD_CYC  = 75_000_000;   // 0.75 s motor gate
  localparam int DEF_PAUSE_CYC = 150_000_000;  // 1.5 s navigation pause
  localparam int DEF_TIMER_W   = 28;           // 2^28 > 150e6

  // The strike counter only has to reach MAX_STRIKES-1; the next counted
  // rise goes to LOCKOUT instead of incrementing. Always at least one bit.
  function automatic int strike_width(input int max_strikes);
    int w;
    w = $clog2(max_strikes);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  // Registered output decode helpers, one per output, keyed on state.
  function automatic logic state_enable(input state_t s);
    return (s == IDLE) || (s == RESUME);
  endfunction

  function automatic logic state_pause(input state_t s);
    return (s != IDLE);
  endfunction

  function automatic logic state_lockout(input state_t s);
    return (s == LOCKOUT);
  endfunction

endpackage

// File: rtl/sns_trig_detect.sv
// Sensor trigger front end: masks the per-channel disable requests, ORs
// them into a single trigger and detects its rising edge.
module sns_trig_detect #(
  parameter int NUM_SNS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SNS-1:0] sns_disable,
  input  logic [NUM_SNS-1:0] sns_mask,
  output logic               trig,
  output logic               rise,
  output logic [NUM_SNS-1:0] masked
);

  logic trig_q_reg;

  // Per-channel masking: a channel with mask 0 can never contribute.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SNS; gi++) begin : g_mask
      assign masked[gi] = sns_disable[gi] & sns_mask[gi];
    end
  endgenerate

  assign trig = |masked;
  assign rise = trig & ~trig_q_reg;

  // Previous-cycle trigger, used for rising-edge (strike) detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q_reg <= 1'b0;
    end else begin
      trig_q_reg <= trig;
    end
  end

endmodule

// File: rtl/disable_sequencer.sv
// Drivetrain sensor-disable sequencer.
// A masked sensor trigger drops 'enable' for HOLD_CYC cycles and raises
// 'pause' for PAUSE_CYC cycles. Repeated rising triggers inside one pause
// episode are counted as strikes; reaching MAX_STRIKES latches LOCKOUT,
// which only a 'clr' pulse with all active sensors quiet releases.
// 'cause' accumulates the channels that contributed to the episode.
//
// Parameter constraints (not checked in hardware):
//   HOLD_CYC >= 1, PAUSE_CYC > HOLD_CYC, 2^TIMER_W > PAUSE_CYC,
//   MAX_STRIKES >= 1. Under these the timer reaches its terminal
//   compare before it could wrap.
module disable_sequencer
  import disable_pkg::*;
#(
  parameter int NUM_SNS     = 2,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int PAUSE_CYC   = DEF_PAUSE_CYC,
  parameter int TIMER_W     = DEF_TIMER_W,
  parameter int RETRIGGER   = 1,
  parameter int MAX_STRIKES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SNS-1:0] sns_disable,
  input  logic [NUM_SNS-1:0] sns_mask,
  input  logic               clr,
  output logic               enable,
  output logic               pause,
  output logic               lockout,
  output logic [NUM_SNS-1:0] cause,
  output logic [1:0]         state
);

  localparam int STRIKE_W = strike_width(MAX_STRIKES);

  localparam logic [TIMER_W-1:0]  HOLD_LAST   = TIMER_W'(HOLD_CYC - 1);
  localparam logic [TIMER_W-1:0]  PAUSE_LAST  = TIMER_W'(PAUSE_CYC - 1);
  localparam logic [TIMER_W-1:0]  TIMER_ONE   = TIMER_W'(1);
  localparam logic [STRIKE_W-1:0] STRIKE_LAST = STRIKE_W'(MAX_STRIKES - 1);
  localparam logic [STRIKE_W-1:0] STRIKE_ONE  = STRIKE_W'(1);

  // Trigger front end.
  logic               trig;
  logic               rise;
  logic [NUM_SNS-1:0] masked;

  sns_trig_detect #(
    .NUM_SNS (NUM_SNS)
  ) u_trig (
    .clk         (clk),
    .rst         (rst),
    .sns_disable (sns_disable),
    .sns_mask    (sns_mask),
    .trig        (trig),
    .rise        (rise),
    .masked      (masked)
  );

  // Sequencer state.
  state_t              state_reg,   state_next;
  logic [TIMER_W-1:0]  timer_reg,   timer_next;
  logic [STRIKE_W-1:0] strikes_reg, strikes_next;
  logic [NUM_SNS-1:0]  cause_reg,   cause_next;

  // Registered outputs, decoded from the next state so they change on
  // the same edge as the state itself.
  logic enable_reg;
  logic pause_reg;
  logic lockout_reg;

  // A counted rise that would reach the strike limit; this overrides any
  // HOLD/RESUME transition on the same edge.
  logic strike_out;
  assign strike_out = rise && (strikes_reg == STRIKE_LAST);

  // Whether a trigger in HOLD restarts the hold timer.
  logic hold_restart;
  assign hold_restart = (RETRIGGER != 0) && trig;

  // State, timer, strike counter and cause register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      strikes_reg <= '0;
      cause_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      strikes_reg <= strikes_next;
      cause_reg   <= cause_next;
    end
  end

  // Next-state logic for the episode FSM and its datapath.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    strikes_next = strikes_reg;
    cause_next   = cause_reg;

    case (state_reg)
      IDLE: begin
        // The trigger that opens an episode is never counted as a strike.
        if (trig) begin
          state_next   = HOLD;
          timer_next   = '0;
          strikes_next = '0;
          cause_next   = masked;
        end
      end

      HOLD: begin
        cause_next = cause_reg | masked;
        if (strike_out) begin
          // Timer is left where it is; it stays frozen in LOCKOUT.
          state_next = LOCKOUT;
        end else begin
          if (rise) begin
            strikes_next = strikes_reg + STRIKE_ONE;
          end
          if (hold_restart) begin
            // Keeps the motor gated for as long as a sensor is asserted.
            timer_next = '0;
          end else begin
            timer_next = timer_reg + TIMER_ONE;
            if (timer_reg == HOLD_LAST) begin
              state_next = RESUME;
            end
          end
        end
      end

      RESUME: begin
        cause_next = cause_reg | masked;
        if (strike_out) begin
          state_next = LOCKOUT;
        end else begin
          if (rise) begin
            strikes_next = strikes_reg + STRIKE_ONE;
          end
          if (trig) begin
            // Any trigger while moving again re-gates the motor,
            // independent of the retrigger setting.
            state_next = HOLD;
            timer_next = '0;
          end else if (timer_reg == PAUSE_LAST) begin
            state_next = IDLE;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + TIMER_ONE;
          end
        end
      end

      LOCKOUT: begin
        cause_next = cause_reg | masked;
        // Clearing while a sensor is still asserted would immediately
        // re-enter the fault, so it is refused.
        if (clr && !trig) begin
          state_next   = IDLE;
          strikes_next = '0;
          cause_next   = '0;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Output decode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_reg  <= 1'b1;
      pause_reg   <= 1'b0;
      lockout_reg <= 1'b0;
    end else begin
      enable_reg  <= state_enable(state_next);
      pause_reg   <= state_pause(state_next);
      lockout_reg <= state_lockout(state_next);
    end
  end

  assign enable  = enable_reg;
  assign pause   = pause_reg;
  assign lockout = lockout_reg;
  assign cause   = cause_reg;
  assign state   = state_reg;

endmodule
